// File: rtl/iosram_io_arbiter_if.sv
// Requester-side and IO-bus-side signals of the IO read arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface iosram_io_arbiter_if #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned IO_ADDR_WIDTH = 16,
  parameter int unsigned IO_DATA_WIDTH = 256
);
  logic [NUM_REQ-1:0]               req_en;
  logic [NUM_REQ*IO_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0]               rsp_valid;
  logic [IO_DATA_WIDTH-1:0]         rsp_data;
  logic [NUM_REQ-1:0]               overflow;
  logic [NUM_REQ-1:0]               clear_overflow;
  logic                             busy;
  logic                             io_en;
  logic [IO_ADDR_WIDTH-1:0]         io_addr;
  logic [IO_DATA_WIDTH-1:0]         io_data;

  modport slave (
    input  req_en, req_addr, clear_overflow, io_data,
    output req_ready, rsp_valid, rsp_data, overflow, busy, io_en, io_addr
  );

  modport master (
    output req_en, req_addr, clear_overflow, io_data,
    input  req_ready, rsp_valid, rsp_data, overflow, busy, io_en, io_addr
  );
endinterface

// File: rtl/iosram_io_arbiter.sv
// Round-robin arbiter sharing one IO read bus among several IO-SRAM read ports.
// Per-requester address FIFOs, one grant per cycle, tag pipeline routes data back.
module iosram_io_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned IO_ADDR_WIDTH = 16,
  parameter int unsigned IO_DATA_WIDTH = 256,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rst,
  iosram_io_arbiter_if.slave  bus_io
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IO_ADDR_WIDTH-1:0]               mem_q [NUM_REQ][FIFO_DEPTH];
  logic [NUM_REQ-1:0][PtrW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [NUM_REQ-1:0]                     empty, full;
  logic [IdxW-1:0]                        last_grant_q;
  logic                                   io_en_q;
  logic [IO_ADDR_WIDTH-1:0]               io_addr_q;
  logic [READ_LATENCY-1:0]                tag_vld_q;
  logic [READ_LATENCY-1:0][IdxW-1:0]      tag_idx_q;
  logic [NUM_REQ-1:0]                     rsp_valid_q;
  logic [IO_DATA_WIDTH-1:0]               rsp_data_q;
  logic [NUM_REQ-1:0]                     overflow_q;
  logic                                   gnt_vld;
  logic [IdxW-1:0]                        gnt_idx;
  int unsigned                            lg, cand;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PtrW-1] != rd_ptr_q[i][PtrW-1]) &&
                 (wr_ptr_q[i][PtrW-2:0] == rd_ptr_q[i][PtrW-2:0]);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant_q;
    lg      = 32'(last_grant_q);
    cand    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (lg + k) % NUM_REQ;
      if (!gnt_vld && !empty[IdxW'(cand)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IdxW'(cand);
      end
    end
  end

  // FIFO storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus_io.req_en[i] && !full[i]) begin
        mem_q[i][wr_ptr_q[i][PtrW-2:0]] <= bus_io.req_addr[i*IO_ADDR_WIDTH +: IO_ADDR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      last_grant_q <= IdxW'(NUM_REQ - 1);
      io_en_q      <= 1'b0;
      io_addr_q    <= '0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      overflow_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus_io.req_en[i] && !full[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        end
        overflow_q[i] <= (bus_io.req_en[i] && full[i]) ||
                         (overflow_q[i] && !bus_io.clear_overflow[i]);
      end
      io_en_q <= gnt_vld;
      if (gnt_vld) begin
        io_addr_q         <= mem_q[gnt_idx][rd_ptr_q[gnt_idx][PtrW-2:0]];
        rd_ptr_q[gnt_idx] <= rd_ptr_q[gnt_idx] + PtrW'(1);
        last_grant_q      <= gnt_idx;
      end
      // last_grant_q names the owner of the read currently on the bus.
      tag_vld_q[0] <= io_en_q;
      tag_idx_q[0] <= last_grant_q;
      for (int j = 1; j < READ_LATENCY; j++) begin
        tag_vld_q[j] <= tag_vld_q[j-1];
        tag_idx_q[j] <= tag_idx_q[j-1];
      end
      rsp_valid_q <= '0;
      if (tag_vld_q[READ_LATENCY-1]) begin
        rsp_valid_q[tag_idx_q[READ_LATENCY-1]] <= 1'b1;
        rsp_data_q                             <= bus_io.io_data;
      end
    end
  end

  assign bus_io.req_ready = ~full;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_data  = rsp_data_q;
  assign bus_io.overflow  = overflow_q;
  assign bus_io.busy      = (|(~empty)) | io_en_q | (|tag_vld_q);
  assign bus_io.io_en     = io_en_q;
  assign bus_io.io_addr   = io_addr_q;

endmodule
